// File: rtl/router_pkt_reg.sv
// rtl/router_pkt_reg.sv - 1xN router packet datapath register with one-byte FIFO skid hold and parity/length check
// Optional statistics counters: define ROUTER_PKT_REG_STATS_EN.
module router_pkt_reg #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              soft_rst,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              fifo_full,
    output logic              out_wr,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] dest_addr,
    output logic              dest_valid,
    output logic              parity_done,
    output logic              err,
    output logic              len_err
`ifdef ROUTER_PKT_REG_STATS_EN
    ,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       perr_cnt,
    output logic [15:0]       lerr_cnt
`endif
);
    localparam int LEN_W = DATA_W - ADDR_W;

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

    state_t             state;
    logic               hold_valid;
    logic [DATA_W-1:0]  hold_data;
    logic [DATA_W-1:0]  acc;
    logic [LEN_W-1:0]   count;
    logic [LEN_W-1:0]   hdr_len;
    logic               accept;

    // in_ready depends only on the hold register, never on fifo_full directly
    assign in_ready = !hold_valid;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            acc         <= '0;
            count       <= '0;
            hdr_len     <= '0;
            out_wr      <= 1'b0;
            out_data    <= '0;
            dest_addr   <= '0;
            dest_valid  <= 1'b0;
            parity_done <= 1'b0;
            err         <= 1'b0;
            len_err     <= 1'b0;
        end else if (soft_rst) begin
            state       <= IDLE;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            acc         <= '0;
            count       <= '0;
            hdr_len     <= '0;
            out_wr      <= 1'b0;
            out_data    <= '0;
            dest_valid  <= 1'b0;
            parity_done <= 1'b0;
            err         <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            dest_valid  <= 1'b0;
            parity_done <= 1'b0;

            if (hold_valid) begin
                if (!fifo_full) begin
                    out_wr     <= 1'b1;
                    out_data   <= hold_data;
                    hold_valid <= 1'b0;
                end else begin
                    out_wr <= 1'b0;
                end
            end else if (accept) begin
                if (!fifo_full) begin
                    out_wr   <= 1'b1;
                    out_data <= in_data;
                end else begin
                    out_wr     <= 1'b0;
                    hold_valid <= 1'b1;
                    hold_data  <= in_data;
                end
            end else begin
                out_wr <= 1'b0;
            end

            // CHECK lasts one cycle but accepts a new header just like IDLE
            case (state)
                IDLE, CHECK: begin
                    state <= IDLE;
                    if (accept) begin
                        dest_addr  <= in_data[ADDR_W-1:0];
                        dest_valid <= 1'b1;
                        acc        <= in_data;
                        count      <= '0;
                        hdr_len    <= in_data[DATA_W-1:ADDR_W];
                        err        <= 1'b0;
                        if (in_last) begin
                            len_err     <= 1'b1;
                            parity_done <= 1'b1;
                        end else begin
                            len_err <= 1'b0;
                            state   <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        if (in_last) begin
                            err         <= (in_data != acc);
                            len_err     <= (count != hdr_len);
                            parity_done <= 1'b1;
                            state       <= CHECK;
                        end else begin
                            acc <= acc ^ in_data;
                            if (count != {LEN_W{1'b1}}) begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROUTER_PKT_REG_STATS_EN
    // Counters survive soft_rst so the controller can see aborted-traffic history
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pkt_cnt  <= '0;
            perr_cnt <= '0;
            lerr_cnt <= '0;
        end else if (parity_done) begin
            if (pkt_cnt != 16'hFFFF) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (err && perr_cnt != 16'hFFFF) begin
                perr_cnt <= perr_cnt + 16'd1;
            end
            if (len_err && lerr_cnt != 16'hFFFF) begin
                lerr_cnt <= lerr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_pkt_reg.sv
// tb/tb_router_pkt_reg.sv - table-driven bench for router_pkt_reg
module tb_router_pkt_reg;
    logic       clk = 1'b0;
    logic       rstn;
    logic       soft_rst;
    logic       in_valid;
    logic       in_last;
    logic [7:0] in_data;
    logic       in_ready;
    logic       fifo_full;
    logic       out_wr;
    logic [7:0] out_data;
    logic [1:0] dest_addr;
    logic       dest_valid;
    logic       parity_done;
    logic       err;
    logic       len_err;
`ifdef ROUTER_PKT_REG_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] perr_cnt;
    logic [15:0] lerr_cnt;
`endif

    router_pkt_reg #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk(clk), .rstn(rstn), .soft_rst(soft_rst),
        .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
        .fifo_full(fifo_full), .out_wr(out_wr), .out_data(out_data),
        .dest_addr(dest_addr), .dest_valid(dest_valid), .parity_done(parity_done),
        .err(err), .len_err(len_err)
`ifdef ROUTER_PKT_REG_STATS_EN
        , .pkt_cnt(pkt_cnt), .perr_cnt(perr_cnt), .lerr_cnt(lerr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       l;
        logic [7:0] d;
        logic       ff;
        logic       sr;
        logic       rdy;
        logic       wr;
        logic [7:0] od;
        logic       dv;
        logic [1:0] da;
        logic       pd;
        logic       e;
        logic       le;
    } vec_t;

    vec_t vecs[$];
    int   applied = 0;
    int   miscompares = 0;
    int   stats_a = -1;
    int   stats_b = -1;

    task automatic add(input logic v, input logic l, input logic [7:0] d, input logic ff, input logic sr,
                       input logic rdy, input logic wr, input logic [7:0] od, input logic dv,
                       input logic [1:0] da, input logic pd, input logic e, input logic le);
        vec_t t;
        t.v = v; t.l = l; t.d = d; t.ff = ff; t.sr = sr;
        t.rdy = rdy; t.wr = wr; t.od = od; t.dv = dv; t.da = da; t.pd = pd; t.e = e; t.le = le;
        vecs.push_back(t);
    endtask

    task automatic check_stats(input string name, input logic [15:0] p, input logic [15:0] pe, input logic [15:0] le);
`ifdef ROUTER_PKT_REG_STATS_EN
        applied++;
        if ({pkt_cnt, perr_cnt, lerr_cnt} !== {p, pe, le}) begin
            miscompares++;
            $display("FAIL %s: pkt/perr/lerr got %0d/%0d/%0d expected %0d/%0d/%0d",
                     name, pkt_cnt, perr_cnt, lerr_cnt, p, pe, le);
        end
`endif
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] exp;

        // good packet; next header lands in the CHECK cycle
        add(1,0,8'h0D,0,0, 1,1,8'h0D,1,2'd1,0,0,0);
        add(1,0,8'h11,0,0, 1,1,8'h11,0,2'd1,0,0,0);
        add(1,0,8'h22,0,0, 1,1,8'h22,0,2'd1,0,0,0);
        add(1,0,8'h33,0,0, 1,1,8'h33,0,2'd1,0,0,0);
        add(1,1,8'h0D,0,0, 1,1,8'h0D,0,2'd1,1,0,0);
        // bad parity, err held through idle cycles
        add(1,0,8'h0D,0,0, 1,1,8'h0D,1,2'd1,0,0,0);
        add(1,0,8'h11,0,0, 1,1,8'h11,0,2'd1,0,0,0);
        add(1,0,8'h22,0,0, 1,1,8'h22,0,2'd1,0,0,0);
        add(1,0,8'h33,0,0, 1,1,8'h33,0,2'd1,0,0,0);
        add(1,1,8'h0C,0,0, 1,1,8'h0C,0,2'd1,1,1,0);
        add(0,0,8'h00,0,0, 1,0,8'h00,0,2'd1,0,1,0);
        add(0,0,8'h00,0,0, 1,0,8'h00,0,2'd1,0,1,0);
        // length mismatch: header says 2, three payload bytes, parity correct (0x09)
        add(1,0,8'h09,0,0, 1,1,8'h09,1,2'd1,0,0,0);
        add(1,0,8'h11,0,0, 1,1,8'h11,0,2'd1,0,0,0);
        add(1,0,8'h22,0,0, 1,1,8'h22,0,2'd1,0,0,0);
        add(1,0,8'h33,0,0, 1,1,8'h33,0,2'd1,0,0,0);
        add(1,1,8'h09,0,0, 1,1,8'h09,0,2'd1,1,0,1);
        add(0,0,8'h00,0,0, 1,0,8'h00,0,2'd1,0,0,1);
        add(0,0,8'h00,0,0, 1,0,8'h00,0,2'd1,0,0,1);
        stats_a = vecs.size() - 1;
        // soft_rst while idle: flags clear, address kept, counters kept
        add(0,0,8'h00,0,1, 1,0,8'h00,0,2'd1,0,0,0);
        stats_b = vecs.size() - 1;
        // back-pressure on 0x22 for three cycles, 0x33 offered but refused meanwhile
        add(1,0,8'h0D,0,0, 1,1,8'h0D,1,2'd1,0,0,0);
        add(1,0,8'h11,0,0, 1,1,8'h11,0,2'd1,0,0,0);
        add(1,0,8'h22,1,0, 0,0,8'h00,0,2'd1,0,0,0);
        add(1,0,8'h33,1,0, 0,0,8'h00,0,2'd1,0,0,0);
        add(1,0,8'h33,1,0, 0,0,8'h00,0,2'd1,0,0,0);
        add(1,0,8'h33,0,0, 1,1,8'h22,0,2'd1,0,0,0);
        add(1,0,8'h33,0,0, 1,1,8'h33,0,2'd1,0,0,0);
        add(1,1,8'h0D,0,0, 1,1,8'h0D,0,2'd1,1,0,0);
        add(0,0,8'h00,0,0, 1,0,8'h00,0,2'd1,0,0,0);
        // soft_rst mid-payload beats a simultaneous accept; 0x05 is then a header
        add(1,0,8'h0D,0,0, 1,1,8'h0D,1,2'd1,0,0,0);
        add(1,0,8'h11,0,0, 1,1,8'h11,0,2'd1,0,0,0);
        add(1,0,8'h22,0,1, 1,0,8'h00,0,2'd1,0,0,0);
        add(1,0,8'h05,0,0, 1,1,8'h05,1,2'd1,0,0,0);
        add(1,0,8'hAA,0,0, 1,1,8'hAA,0,2'd1,0,0,0);
        add(1,1,8'hAF,0,0, 1,1,8'hAF,0,2'd1,1,0,0);
        // zero-length packet, header in CHECK cycle
        add(1,0,8'h02,0,0, 1,1,8'h02,1,2'd2,0,0,0);
        add(1,1,8'h02,0,0, 1,1,8'h02,0,2'd2,1,0,0);
        add(0,0,8'h00,0,0, 1,0,8'h00,0,2'd2,0,0,0);
        // header carrying in_last
        add(1,1,8'h03,0,0, 1,1,8'h03,1,2'd3,1,0,1);
        add(0,0,8'h00,0,0, 1,0,8'h00,0,2'd3,0,0,1);
        // parity byte held: parity_done precedes its out_wr
        add(1,0,8'h04,0,0, 1,1,8'h04,1,2'd0,0,0,0);
        add(1,0,8'h10,0,0, 1,1,8'h10,0,2'd0,0,0,0);
        add(1,1,8'h14,1,0, 0,0,8'h00,0,2'd0,1,0,0);
        add(0,0,8'h00,0,0, 1,1,8'h14,0,2'd0,0,0,0);
        add(0,0,8'h00,0,0, 1,0,8'h00,0,2'd0,0,0,0);

        rstn = 1'b0; soft_rst = 1'b0; in_valid = 1'b1; in_last = 1'b0; in_data = 8'hFF; fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applied++;
        if ({in_ready, out_wr, out_data, dest_addr, dest_valid, parity_done, err, len_err} !== 16'h8000) begin
            miscompares++;
            $display("FAIL reset: got %h expected 8000",
                     {in_ready, out_wr, out_data, dest_addr, dest_valid, parity_done, err, len_err});
        end
        check_stats("reset_stats", 16'd0, 16'd0, 16'd0);
        rstn = 1'b1; in_valid = 1'b0; in_data = 8'h00;

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].v;
            in_last   = vecs[i].l;
            in_data   = vecs[i].d;
            fifo_full = vecs[i].ff;
            soft_rst  = vecs[i].sr;
            @(posedge clk);
            #1;
            got = {in_ready, out_wr, (vecs[i].wr ? out_data : 8'h00), dest_valid, dest_addr, parity_done, err, len_err};
            exp = {vecs[i].rdy, vecs[i].wr, (vecs[i].wr ? vecs[i].od : 8'h00), vecs[i].dv, vecs[i].da,
                   vecs[i].pd, vecs[i].e, vecs[i].le};
            applied++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL vec%0d: rdy,wr,data,dv,da,pd,err,len_err got %h expected %h", i, got, exp);
            end
            if (i == stats_a) check_stats("stats_after_3pkts", 16'd3, 16'd1, 16'd1);
            if (i == stats_b) check_stats("stats_after_soft_rst", 16'd3, 16'd1, 16'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
